blind_pixel_encode: RTL and testbench



---
 rtl/blind_pixel_encode_pkg.sv | 27 ++
 rtl/blind_pixel_encode_ctrl_pack.sv | 40 ++++
 rtl/blind_pixel_encode.sv | 126 ++++++++++++
 tb/tb_blind_pixel_encode.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blind_pixel_encode_pkg.sv
// Shared definitions for the Avalon-ST Video packet encoder: state codes,
// packet type nibbles and the control-packet beat count helper.
package blind_pixel_encode_pkg;

    localparam logic [4:0] ST_IDLE      = 5'b00001;
    localparam logic [4:0] ST_CTRL_HDR  = 5'b00010;
    localparam logic [4:0] ST_CTRL_BODY = 5'b00100;
    localparam logic [4:0] ST_DATA_HDR  = 5'b01000;
    localparam logic [4:0] ST_DATA      = 5'b10000;

    localparam logic [3:0] CTRL_TYPE = 4'hF;
    localparam logic [3:0] DATA_TYPE = 4'h0;

    // Width(4) + height(4) + interlace(1) nibbles in one control packet.
    localparam int NIBBLES = 9;

    typedef struct packed {
        logic [15:0] width;
        logic [15:0] height;
        logic [3:0]  interlaced;
    } geom_t;

    function automatic int ctrl_beats(input int planes);
        return (NIBBLES + planes - 1) / planes;
    endfunction

endpackage

// File: rtl/blind_pixel_encode_ctrl_pack.sv
// Combinational control-packet body packer: maps a body beat index and the
// frame geometry onto nibbles placed in the low bits of each colour plane.
module blind_pixel_ctrl_pack
    import blind_pixel_encode_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int COLOR_BITS   = 8,
    parameter int COLOR_PLANES = 3
) (
    input  logic [3:0]            beat_cnt,
    input  geom_t                 geom,
    output logic [DATA_WIDTH-1:0] beat_data
);

    logic [3:0] nib [NIBBLES];

    assign nib[0] = geom.width[15:12];
    assign nib[1] = geom.width[11:8];
    assign nib[2] = geom.width[7:4];
    assign nib[3] = geom.width[3:0];
    assign nib[4] = geom.height[15:12];
    assign nib[5] = geom.height[11:8];
    assign nib[6] = geom.height[7:4];
    assign nib[7] = geom.height[3:0];
    assign nib[8] = geom.interlaced;

    // Nibble k of the sequence lands in plane (k % planes) of beat (k / planes).
    always_comb begin
        int idx;
        idx       = 0;
        beat_data = '0;
        for (int p = 0; p < COLOR_PLANES; p++) begin
            idx = int'(beat_cnt) * COLOR_PLANES + p;
            if (idx < NIBBLES) begin
                beat_data[p*COLOR_BITS +: 4] = nib[idx[3:0]];
            end
        end
    end

endmodule

// File: rtl/blind_pixel_encode.sv
// Avalon-ST Video encoder: wraps each raw framed pixel stream in a control
// packet (geometry) followed by a data packet header and pass-through pixels.
module blind_pixel_encode
    import blind_pixel_encode_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int COLOR_BITS   = 8,
    parameter int COLOR_PLANES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic                  din_ready,
    input  logic [15:0]           im_width,
    input  logic [15:0]           im_height,
    input  logic [3:0]            im_interlaced,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic [4:0]            state_dbg
);

    localparam logic [3:0] LAST_BEAT = 4'(ctrl_beats(COLOR_PLANES) - 1);

    // Handshake: a beat moves on either port only on a cycle where valid and
    // ready are both high; a held beat stays unchanged until that happens.
    logic [4:0]            state;
    logic [3:0]            beat_cnt;
    geom_t                 geom;
    logic [DATA_WIDTH-1:0] body_data;

    blind_pixel_ctrl_pack #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COLOR_BITS  (COLOR_BITS),
        .COLOR_PLANES(COLOR_PLANES)
    ) u_ctrl_pack (
        .beat_cnt (beat_cnt),
        .geom     (geom),
        .beat_data(body_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            geom     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The SOP pixel is left waiting on din until DATA.
                    if (din_valid && din_startofpacket) begin
                        geom  <= {im_width, im_height, im_interlaced};
                        state <= ST_CTRL_HDR;
                    end
                end
                ST_CTRL_HDR: begin
                    if (dout_ready) begin
                        state    <= ST_CTRL_BODY;
                        beat_cnt <= '0;
                    end
                end
                ST_CTRL_BODY: begin
                    if (dout_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= ST_DATA_HDR;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA_HDR: begin
                    if (dout_ready) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (din_valid && dout_ready && din_endofpacket) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dout_data          = din_data;
        dout_valid         = 1'b0;
        dout_startofpacket = 1'b0;
        dout_endofpacket   = 1'b0;
        din_ready          = 1'b0;
        case (state)
            ST_IDLE: begin
                din_ready = !din_startofpacket;
            end
            ST_CTRL_HDR: begin
                dout_data          = DATA_WIDTH'(CTRL_TYPE);
                dout_valid         = 1'b1;
                dout_startofpacket = 1'b1;
            end
            ST_CTRL_BODY: begin
                dout_data        = body_data;
                dout_valid       = 1'b1;
                dout_endofpacket = (beat_cnt == LAST_BEAT);
            end
            ST_DATA_HDR: begin
                dout_data          = DATA_WIDTH'(DATA_TYPE);
                dout_valid         = 1'b1;
                dout_startofpacket = 1'b1;
            end
            ST_DATA: begin
                dout_valid       = din_valid;
                din_ready        = dout_ready;
                dout_endofpacket = din_endofpacket;
            end
            default: ;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_blind_pixel_encode.sv
// Bench for blind_pixel_encode: a 3-plane and a 1-plane instance driven by
// frame tasks, checked against a geometry-to-beats model in a scoreboard.
module tb_blind_pixel_encode;
    import blind_pixel_encode_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [2];
    logic [23:0] din_data    [2];
    logic        din_valid   [2];
    logic        din_sop     [2];
    logic        din_eop     [2];
    logic        din_ready   [2];
    logic [15:0] im_w        [2];
    logic [15:0] im_h        [2];
    logic [3:0]  im_i        [2];
    logic        dout_valid  [2];
    logic        dout_sop    [2];
    logic        dout_eop    [2];
    logic        dout_ready  [2];
    logic        busy        [2];
    logic [4:0]  st          [2];
    logic [23:0] dout0;
    logic [7:0]  dout1;
    logic [23:0] dout_x      [2];
    assign dout_x[0] = dout0;
    assign dout_x[1] = {16'h0, dout1};

    blind_pixel_encode #(.DATA_WIDTH(24), .COLOR_BITS(8), .COLOR_PLANES(3)) dut3 (
        .clk(clk), .rst(rst[0]), .din_data(din_data[0]), .din_valid(din_valid[0]),
        .din_startofpacket(din_sop[0]), .din_endofpacket(din_eop[0]), .din_ready(din_ready[0]),
        .im_width(im_w[0]), .im_height(im_h[0]), .im_interlaced(im_i[0]),
        .dout_data(dout0), .dout_valid(dout_valid[0]), .dout_startofpacket(dout_sop[0]),
        .dout_endofpacket(dout_eop[0]), .dout_ready(dout_ready[0]), .busy(busy[0]),
        .state_dbg(st[0])
    );

    blind_pixel_encode #(.DATA_WIDTH(8), .COLOR_BITS(8), .COLOR_PLANES(1)) dut1 (
        .clk(clk), .rst(rst[1]), .din_data(din_data[1][7:0]), .din_valid(din_valid[1]),
        .din_startofpacket(din_sop[1]), .din_endofpacket(din_eop[1]), .din_ready(din_ready[1]),
        .im_width(im_w[1]), .im_height(im_h[1]), .im_interlaced(im_i[1]),
        .dout_data(dout1), .dout_valid(dout_valid[1]), .dout_startofpacket(dout_sop[1]),
        .dout_endofpacket(dout_eop[1]), .dout_ready(dout_ready[1]), .busy(busy[1]),
        .state_dbg(st[1])
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard: {sop, eop, data} ----------------
    logic [25:0] exp_q0[$];
    logic [25:0] exp_q1[$];
    int          pop_cnt   [2];
    logic        held      [2];
    logic [25:0] held_beat [2];
    int          mode      [2];
    logic [23:0] pix_q[$];

    task automatic push_exp(input int u, input logic sop, input logic eop, input logic [23:0] d);
        if (u == 0) exp_q0.push_back({sop, eop, d});
        else        exp_q1.push_back({sop, eop, d});
    endtask

    task automatic pop_beat(input int u, input logic [25:0] cur);
        logic [25:0] e;
        if (u == 0) begin
            check_eq("beat_expected0", 32'(exp_q0.size() != 0), 32'd1);
            if (exp_q0.size() != 0) begin
                e = exp_q0.pop_front();
                check_eq("beat0", 32'(cur), 32'(e));
            end
        end else begin
            check_eq("beat_expected1", 32'(exp_q1.size() != 0), 32'd1);
            if (exp_q1.size() != 0) begin
                e = exp_q1.pop_front();
                check_eq("beat1", 32'(cur), 32'(e));
            end
        end
        pop_cnt[u]++;
    endtask

    always @(negedge clk) begin
        logic [25:0] cur;
        for (int u = 0; u < 2; u++) begin
            cur = {dout_sop[u], dout_eop[u], dout_x[u]};
            if (dout_valid[u]) begin
                if (held[u]) check_eq("stable", 32'(cur), 32'(held_beat[u]));
                if (dout_ready[u]) begin
                    pop_beat(u, cur);
                    held[u] = 1'b0;
                end else begin
                    held[u]      = 1'b1;
                    held_beat[u] = cur;
                end
            end else if (held[u]) begin
                check_eq("valid_held", 32'd0, 32'd1);
                held[u] = 1'b0;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            case (mode[u])
                0:       dout_ready[u] = 1'b1;
                1:       dout_ready[u] = ~dout_ready[u];
                default: dout_ready[u] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- reference model ----------------
    // One frame = CTRL header, ceil(9/planes) body beats, DATA header, pixels.
    task automatic model_frame(input int u, input logic [15:0] w, input logic [15:0] h,
                               input logic [3:0] i);
        int          planes;
        int          nbeats;
        int          k;
        logic [3:0]  nib [9];
        logic [23:0] d;
        planes = (u == 0) ? 3 : 1;
        for (int j = 0; j < 4; j++) begin
            nib[j]     = 4'((w >> (12 - 4 * j)) & 16'hF);
            nib[4 + j] = 4'((h >> (12 - 4 * j)) & 16'hF);
        end
        nib[8] = i;
        nbeats = (9 + planes - 1) / planes;
        push_exp(u, 1'b1, 1'b0, 24'h00000F);
        for (int b = 0; b < nbeats; b++) begin
            d = '0;
            for (int p = 0; p < planes; p++) begin
                k = b * planes + p;
                if (k < 9) d = d | (24'(nib[k]) << (8 * p));
            end
            push_exp(u, 1'b0, b == nbeats - 1, d);
        end
        push_exp(u, 1'b1, 1'b0, 24'h0);
        for (int j = 0; j < pix_q.size(); j++) begin
            push_exp(u, 1'b0, j == pix_q.size() - 1, (u == 0) ? pix_q[j] : (pix_q[j] & 24'hFF));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_accept(input int u);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = din_valid[u] && din_ready[u];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_frame(input int u, input logic [15:0] w, input logic [15:0] h,
                               input logic [3:0] i, input bit gaps);
        for (int j = 0; j < pix_q.size(); j++) begin
            if (j == 0) begin
                im_w[u] = w;
                im_h[u] = h;
                im_i[u] = i;
            end
            din_data[u]  = pix_q[j];
            din_sop[u]   = (j == 0) || (gaps && $urandom_range(0, 3) == 0);
            din_eop[u]   = (j == pix_q.size() - 1);
            din_valid[u] = 1'b1;
            wait_accept(u);
            if (j == 0) begin
                im_w[u] = 16'($urandom);
                im_h[u] = 16'($urandom);
                im_i[u] = 4'($urandom);
            end
            if (gaps && j != pix_q.size() - 1 && $urandom_range(0, 1) == 1) begin
                din_valid[u] = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        din_valid[u] = 1'b0;
        din_sop[u]   = 1'b0;
        din_eop[u]   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain0", 32'(exp_q0.size()), 32'd0);
        check_eq("drain1", 32'(exp_q1.size()), 32'd0);
    endtask

    task automatic push_literal_3plane();
        push_exp(0, 1'b1, 1'b0, 24'h00000F);
        push_exp(0, 1'b0, 1'b0, 24'h080200);
        push_exp(0, 1'b0, 1'b0, 24'h010000);
        push_exp(0, 1'b0, 1'b1, 24'h00000E);
        push_exp(0, 1'b1, 1'b0, 24'h000000);
        push_exp(0, 1'b0, 1'b0, 24'h112233);
        push_exp(0, 1'b0, 1'b1, 24'h445566);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0]  nb [9];
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0]  i;
        int          base;
        int          n;
        int          u;

        nb = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h5, 4'h6, 4'h3};
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; din_data[k] = '0; din_valid[k] = 1'b0; din_sop[k] = 1'b0;
            din_eop[k] = 1'b0; im_w[k] = '0; im_h[k] = '0; im_i[k] = '0;
            dout_ready[k] = 1'b1; mode[k] = 0; held[k] = 1'b0; pop_cnt[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_busy", 32'(busy[k]), 32'd0);
            check_eq("rst_valid", 32'(dout_valid[k]), 32'd0);
            check_eq("rst_sop", 32'(dout_sop[k]), 32'd0);
            check_eq("rst_eop", 32'(dout_eop[k]), 32'd0);
            check_eq("rst_din_ready", 32'(din_ready[k]), 32'd1);
            check_eq("rst_state", 32'(st[k]), 32'(ST_IDLE));
        end
        din_sop[0] = 1'b1;
        #1;
        check_eq("idle_sop_ready", 32'(din_ready[0]), 32'd0);
        din_sop[0] = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // 3 planes, 640x480, two pixels, sink always ready
        pix_q = '{24'h112233, 24'h445566};
        push_literal_3plane();
        drive_frame(0, 16'd640, 16'd480, 4'd0, 1'b0);
        drain();

        // Same frame with sink ready toggling every cycle
        mode[0] = 1;
        push_literal_3plane();
        drive_frame(0, 16'd640, 16'd480, 4'd0, 1'b0);
        drain();
        mode[0] = 0;

        // 1 plane: nine body beats carrying one nibble each
        pix_q = '{24'h0000A5, 24'h00003C, 24'h0000FF};
        push_exp(1, 1'b1, 1'b0, 24'h0F);
        for (int k = 0; k < 9; k++) push_exp(1, 1'b0, k == 8, 24'(nb[k]));
        push_exp(1, 1'b1, 1'b0, 24'h0);
        push_exp(1, 1'b0, 1'b0, 24'hA5);
        push_exp(1, 1'b0, 1'b0, 24'h3C);
        push_exp(1, 1'b0, 1'b1, 24'hFF);
        drive_frame(1, 16'h1234, 16'h0056, 4'd3, 1'b0);
        drain();

        // Non-SOP pixels while idle are dropped
        din_valid[0] = 1'b1;
        din_sop[0]   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din_data[0] = 24'($urandom);
            din_eop[0]  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("drop_ready", 32'(din_ready[0]), 32'd1);
            check_eq("drop_valid", 32'(dout_valid[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        din_valid[0] = 1'b0;
        din_eop[0]   = 1'b0;
        pix_q = '{24'h010203, 24'h040506, 24'h070809};
        model_frame(0, 16'd1920, 16'd1080, 4'd2);
        drive_frame(0, 16'd1920, 16'd1080, 4'd2, 1'b0);
        drain();

        // Reset while the second control body beat is on dout
        pix_q = '{24'hAABBCC};
        model_frame(0, 16'd320, 16'd240, 4'd1);
        im_w[0] = 16'd320; im_h[0] = 16'd240; im_i[0] = 4'd1;
        din_data[0] = 24'hAABBCC; din_sop[0] = 1'b1; din_eop[0] = 1'b1; din_valid[0] = 1'b1;
        base = pop_cnt[0];
        n = 0;
        while (pop_cnt[0] < base + 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("rst_reach_body1", 32'(pop_cnt[0] - base), 32'd2);
        rst[0] = 1'b1;
        din_valid[0] = 1'b0; din_sop[0] = 1'b0; din_eop[0] = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", 32'(busy[0]), 32'd0);
        check_eq("midrst_valid", 32'(dout_valid[0]), 32'd0);
        exp_q0.delete();
        held[0] = 1'b0;
        @(posedge clk);
        #1;
        pix_q = '{24'h123456, 24'h789ABC};
        model_frame(0, 16'd800, 16'd600, 4'd0);
        drive_frame(0, 16'd800, 16'd600, 4'd0, 1'b0);
        drain();

        // Back-to-back frames with a new width on the second
        pix_q = '{24'h0A0B0C, 24'h0D0E0F};
        model_frame(0, 16'd100, 16'd50, 4'd0);
        drive_frame(0, 16'd100, 16'd50, 4'd0, 1'b0);
        pix_q = '{24'hFEDCBA};
        model_frame(0, 16'd200, 16'd50, 4'd0);
        drive_frame(0, 16'd200, 16'd50, 4'd0, 1'b0);
        drain();

        // Randomised frames on both instances
        for (int f = 0; f < 24; f++) begin
            u = f % 2;
            mode[u] = $urandom_range(0, 2);
            w = 16'($urandom);
            h = 16'($urandom);
            i = 4'($urandom);
            pix_q.delete();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) pix_q.push_back(24'($urandom));
            model_frame(u, w, h, i);
            drive_frame(u, w, h, i, 1'b1);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
